pc_sequencer: RTL
=================

# pc_sequencer

Next-PC controller for the fetch PC register of the MIPS pipeline. Every cycle it selects the next PC from five sources: sequential PC+4, branch, jump, exception entry and eret return. It drives the PC register's write enable and next value, and holds a redirect that arrives during a stall until the stall releases. It also tracks exception-handler mode and flushes the wrong-path fetch on exception entry and eret.

## Interface
- RESET_PC, 32'h0000_3000, value NPC presents while reset is asserted.
- HANDLER_PC, 32'h0000_4180, exception handler entry address.
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous, active-low reset.
- PC  input  32  current fetch PC from the PC register.
- Stall  input  1  pipeline stall; PC must hold.
- BrTaken  input  1  branch resolved taken in D.
- BrTarget  input  32  branch target.
- JmpReq  input  1  jump/jr/jal in D.
- JmpTarget  input  32  jump target.
- ExcReq  input  1  exception/interrupt accepted by CP0.
- EretReq  input  1  eret in D.
- EPC  input  32  return address from CP0.
- NPC  output  32  next PC to the PC register.
- PcWe  output  1  PC register write enable.
- FlushF  output  1  kill the instruction currently in fetch.
- InExc  output  1  handler mode, set on exception entry, cleared on eret.
- Pending  output  1  redirect latched, waiting for stall release.

## Operation
- Source priority, highest first: ExcReq, EretReq, pending redirect, JmpReq, BrTaken, sequential PC+4.
- If JmpReq and BrTaken are both high, the jump wins.
- ExcReq ignores Stall. It drives NPC=HANDLER_PC, PcWe=1, FlushF=1, sets InExc and clears any pending redirect.
- EretReq with Stall=0 drives NPC=EPC, PcWe=1, FlushF=1, clears InExc and clears pending.
- EretReq with Stall=1 latches EPC as an eret-type pending redirect; FlushF and the InExc clear are applied at release.
- Branch and jump redirects have a delay slot, so they never assert FlushF.
- State machine has two states, RUN and PEND.
  - RUN with Stall=0: NPC = selected source, PcWe=1.
  - RUN with Stall=1 and a Jmp/Br/Eret request: latch target and type, go to PEND, PcWe=0.
  - RUN with Stall=1 and no request: PcWe=0, NPC=PC+4.
  - PEND with Stall=1: PcWe=0. New Jmp/Br requests are ignored. EretReq overwrites the pending entry. ExcReq overrides as above and returns to RUN.
  - PEND with Stall=0: NPC = latched target, PcWe=1, FlushF=1 if the entry is eret-type, go to RUN.
- Pending = (state==PEND).
- PC+4 is modulo 2^32; wraparound is not flagged. Alignment and range errors are detected downstream by the PC register, not here.

## Timing
- NPC, PcWe and FlushF are combinational from the inputs and state. A request at cycle t updates PC at the rising edge ending cycle t (zero added latency) when unstalled.
- A redirect latched during a stall is applied in the first unstalled cycle; PC updates at that cycle's edge.
- Only the state, pending target, pending type and InExc are registers.
- Reset (Rst_n=0, asynchronous):
  - state=RUN, pending cleared, InExc=0.
  - Outputs: PcWe=0, FlushF=0, Pending=0, NPC=RESET_PC.
- Reset deassertion: the first active cycle behaves as RUN with no history.
- Reset asserted mid-PEND discards the pending redirect.
- ExcReq while InExc=1 is accepted (nested entry); InExc stays 1.
- ExcReq and EretReq in the same cycle: the exception wins and InExc stays 1.

## Structure
- Shared package pc_seq_pkg:
  - State enum {RUN, PEND}.
  - Pending-type enum {PT_JMP, PT_BR, PT_ERET}.
  - Constants RESET_PC and HANDLER_PC.
- One sub-module, pc_redirect_arb: purely combinational priority select of {valid, target, flush, type} from the request inputs. The sequencer holds the FSM and registers around it.

## Test plan
- Reset, then three free-running cycles with PC=0x3000, 0x3004, 0x3008 -> NPC=PC+4 each cycle, PcWe=1, FlushF=0, InExc=0.
- BrTaken=1, BrTarget=0x3100, Stall=0 -> same cycle NPC=0x3100, PcWe=1, FlushF=0.
- Same-cycle JmpReq=1 (JmpTarget=0x3200) and BrTaken=1 (BrTarget=0x3100) -> NPC=0x3200.
- Stall=1 with JmpReq=1 (JmpTarget=0x3400) for 3 cycles, then Stall=0:
  - During the stall: PcWe=0, Pending=1, and a BrTaken presented in the second stalled cycle is ignored.
  - First unstalled cycle: NPC=0x3400, PcWe=1, Pending drops next cycle.
- ExcReq=1 during Stall=1 with a pending jump -> NPC=0x4180, PcWe=1, FlushF=1, InExc=1 next cycle, Pending=0.
- Later EretReq=1, EPC=0x3008, Stall=0 -> NPC=0x3008, FlushF=1, InExc=0 next cycle.
- Rst_n pulsed low mid-cycle while Pending=1 -> outputs go to reset values immediately, without waiting for a clock edge. After release: Pending=0, NPC=PC+4.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch next-PC sequencer.
// Holds the FSM state enum, pending-redirect types and fixed PC vectors.
package pc_seq_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    typedef enum logic {
        RUN,
        PEND
    } state_t;

    typedef enum logic [1:0] {
        PT_JMP,
        PT_BR,
        PT_ERET
    } ptype_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] target;
        logic        flush;
        ptype_t      ptype;
    } redirect_t;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational priority select among exception, eret, pending, jump and branch.
// Produces one redirect descriptor; the sequencer decides what to do with it.
module pc_redirect_arb
    import pc_seq_pkg::*;
(
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        pend_valid,
    input  logic [31:0] pend_target,
    input  ptype_t      pend_type,
    input  logic        jmp_req,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output redirect_t   sel,
    output logic        sel_exc
);

    always_comb begin
        sel       = '0;
        sel.ptype = PT_JMP;
        sel_exc   = 1'b0;
        if (exc_req) begin
            sel_exc    = 1'b1;
            sel.valid  = 1'b1;
            sel.target = HANDLER_PC;
            sel.flush  = 1'b1;
        end else if (eret_req) begin
            sel.valid  = 1'b1;
            sel.target = epc;
            sel.flush  = 1'b1;
            sel.ptype  = PT_ERET;
        end else if (pend_valid) begin
            // Only an eret-type entry kills the fetch; branch/jump have a delay slot.
            sel.valid  = 1'b1;
            sel.target = pend_target;
            sel.flush  = (pend_type == PT_ERET);
            sel.ptype  = pend_type;
        end else if (jmp_req) begin
            sel.valid  = 1'b1;
            sel.target = jmp_target;
            sel.ptype  = PT_JMP;
        end else if (br_taken) begin
            sel.valid  = 1'b1;
            sel.target = br_target;
            sel.ptype  = PT_BR;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks the fetch redirect, holds redirects across stalls,
// tracks exception-handler mode and flushes wrong-path fetch on exc/eret.
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] PC,
    input  logic        Stall,
    input  logic        BrTaken,
    input  logic [31:0] BrTarget,
    input  logic        JmpReq,
    input  logic [31:0] JmpTarget,
    input  logic        ExcReq,
    input  logic        EretReq,
    input  logic [31:0] EPC,
    output logic [31:0] NPC,
    output logic        PcWe,
    output logic        FlushF,
    output logic        InExc,
    output logic        Pending
);

    state_t      state, state_n;
    logic [31:0] pend_target, pend_target_n;
    ptype_t      pend_type, pend_type_n;
    logic        in_exc_n;

    redirect_t   sel;
    logic        sel_exc;

    logic [31:0] npc_c;
    logic        pc_we_c;
    logic        flush_c;

    pc_redirect_arb u_arb (
        .exc_req     (ExcReq),
        .eret_req    (EretReq),
        .epc         (EPC),
        .pend_valid  (state == PEND),
        .pend_target (pend_target),
        .pend_type   (pend_type),
        .jmp_req     (JmpReq),
        .jmp_target  (JmpTarget),
        .br_taken    (BrTaken),
        .br_target   (BrTarget),
        .sel         (sel),
        .sel_exc     (sel_exc)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= RUN;
            pend_target <= '0;
            pend_type   <= PT_JMP;
            InExc       <= 1'b0;
        end else begin
            state       <= state_n;
            pend_target <= pend_target_n;
            pend_type   <= pend_type_n;
            InExc       <= in_exc_n;
        end
    end

    always_comb begin
        npc_c         = seq_pc(PC);
        pc_we_c       = 1'b0;
        flush_c       = 1'b0;
        state_n       = state;
        pend_target_n = pend_target;
        pend_type_n   = pend_type;
        in_exc_n      = InExc;

        if (sel_exc) begin
            npc_c    = sel.target;
            pc_we_c  = 1'b1;
            flush_c  = 1'b1;
            state_n  = RUN;
            in_exc_n = 1'b1;
        end else if (!Stall) begin
            pc_we_c = 1'b1;
            state_n = RUN;
            if (sel.valid) begin
                npc_c   = sel.target;
                flush_c = sel.flush;
                if (sel.ptype == PT_ERET)
                    in_exc_n = 1'b0;
            end
        end else if (sel.valid) begin
            // In PEND the arbiter re-selects the held entry unless an eret
            // outranks it, so new jumps/branches cannot displace it here.
            state_n       = PEND;
            pend_target_n = sel.target;
            pend_type_n   = sel.ptype;
        end
    end

    assign NPC     = Rst_n ? npc_c : RESET_PC;
    assign PcWe    = Rst_n & pc_we_c;
    assign FlushF  = Rst_n & flush_c;
    assign Pending = (state == PEND);

endmodule
